// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Purpose  : Time-multiplexes one shared seven-segment decoder across
//            NUM_DIGITS common-anode digits. Each digit gets a BLANK gap
//            (all anodes off, anti-ghosting) followed by a SHOW window.
//            New display values arrive over a valid/ready handshake and are
//            applied only at frame boundaries so the display never tears.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   synchronous reset, active-low
//   en          in   scan enable; low forces blank and restarts at digit 0
//   load_valid  in   new display value offered
//   load_data   in   4*NUM_DIGITS nibbles; digit k = load_data[4k+3:4k]
//   load_ready  out  controller can accept load_data
//   blank_mask  in   1 = digit k never lit (live input)
//   digit_nib   out  nibble for the decoder {X3,X2,X1,X0}
//   anode_n     out  active-low digit enables, one-hot-cold
//   digit_idx   out  index of the currently selected digit
//   frame_tick  out  1-cycle pulse at each frame wrap
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic                          load_valid,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  output logic                          load_ready,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [3:0]                    digit_nib,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int C_MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int C_TW      = $clog2(C_MAX_CYC + 1);
  localparam int C_IW      = $clog2(NUM_DIGITS);

  localparam logic [C_TW-1:0] C_DWELL_LAST = C_TW'(DWELL_CYCLES - 1);
  localparam logic [C_TW-1:0] C_BLANK_LAST = C_TW'(BLANK_CYCLES - 1);
  localparam logic [C_IW-1:0] C_IDX_LAST   = C_IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]              r_state,   w_state_nxt;
  logic [C_TW-1:0]         r_timer,   w_timer_nxt;
  logic [C_IW-1:0]         r_idx,     w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_disp,    w_disp_nxt;
  logic [4*NUM_DIGITS-1:0] r_shadow,  w_shadow_nxt;
  logic                    r_pending, w_pending_nxt;
  logic                    r_ready,   w_ready_nxt;
  logic [3:0]              r_nib,     w_nib_nxt;
  logic [NUM_DIGITS-1:0]   r_anode,   w_anode_nxt;
  logic                    r_tick,    w_tick_nxt;
  logic                    w_wrap;
  logic                    w_accept;

  assign load_ready = r_ready;
  assign digit_nib  = r_nib;
  assign anode_n    = r_anode;
  assign digit_idx  = r_idx;
  assign frame_tick = r_tick;

  // State register: every output is a flop fed from the output-comb process.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_BLANK;
      r_timer   <= '0;
      r_idx     <= '0;
      r_disp    <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
      r_nib     <= 4'd0;
      r_anode   <= '1;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_idx     <= w_idx_nxt;
      r_disp    <= w_disp_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_ready   <= w_ready_nxt;
      r_nib     <= w_nib_nxt;
      r_anode   <= w_anode_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  // Next-state logic: scan sequencing plus the single-entry load buffer.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer + C_TW'(1);
    w_idx_nxt     = r_idx;
    w_wrap        = 1'b0;
    w_disp_nxt    = r_disp;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    w_ready_nxt   = r_ready;
    w_accept      = load_valid & r_ready;

    if (!en) begin
      w_state_nxt = ST_BLANK;
      w_timer_nxt = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (r_timer == C_BLANK_LAST) begin
            w_state_nxt = ST_SHOW;
            w_timer_nxt = '0;
          end
        end
        default: begin
          if (r_timer == C_DWELL_LAST) begin
            w_state_nxt = ST_BLANK;
            w_timer_nxt = '0;
            if (r_idx == C_IDX_LAST) begin
              w_idx_nxt = '0;
              w_wrap    = 1'b1;
            end else begin
              w_idx_nxt = r_idx + C_IW'(1);
            end
          end
        end
      endcase
    end

    if (w_wrap && r_pending) begin
      w_disp_nxt    = r_shadow;
      w_pending_nxt = 1'b0;
      w_ready_nxt   = 1'b1;
    end

    // Ready is low whenever a load is pending, so accept and apply never
    // collide: an accept on the wrap edge waits for the following wrap.
    if (w_accept) begin
      w_shadow_nxt  = load_data;
      w_pending_nxt = 1'b1;
      w_ready_nxt   = 1'b0;
    end
  end

  // Output logic: derived from next-state values so the registered outputs
  // line up with the state they describe (e.g. new disp[0] right after wrap).
  always_comb begin
    w_tick_nxt  = w_wrap;
    w_nib_nxt   = 4'd0;
    w_anode_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_nxt == C_IW'(k)) begin
        w_nib_nxt = w_disp_nxt[4*k +: 4];
        if (w_state_nxt == ST_SHOW) begin
          w_anode_nxt[k] = blank_mask[k];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Purpose  : Self-checking bench for seven_seg_scan_ctrl (4 digits, DWELL=4,
//            BLANK=2). A frame-position model predicts all outputs each cycle;
//            directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int PER   = DW + BL;
  localparam int FRAME = ND * PER;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [3:0]  blank_mask;
  logic [3:0]  digit_nib;
  logic [3:0]  anode_n;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .blank_mask(blank_mask),
    .digit_nib (digit_nib),
    .anode_n   (anode_n),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position inside the frame after each edge. Position 0 is the
  // first BLANK cycle of digit 0; each digit spans BL blank then DW lit.
  int          m_pos;
  logic [15:0] m_disp, m_shadow;
  logic        m_pending, m_ready, m_tick;
  logic [3:0]  m_mask;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    logic acc;
    acc = load_valid && m_ready;
    if (!reset_n) begin
      m_pos = 0; m_disp = '0; m_shadow = '0;
      m_pending = 1'b0; m_ready = 1'b1; m_tick = 1'b0; m_valid = 1'b1;
    end else begin
      m_tick = 1'b0;
      if (!en) begin
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
        if (m_pos == 0) begin
          m_tick = 1'b1;
          if (m_pending) begin
            m_disp = m_shadow; m_pending = 1'b0; m_ready = 1'b1;
          end
        end
      end
      if (acc) begin
        m_shadow = load_data; m_pending = 1'b1; m_ready = 1'b0;
      end
    end
    m_mask = blank_mask;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      int   e_idx;
      logic [3:0] e_anode;
      e_idx   = m_pos / PER;
      e_anode = 4'hF;
      if ((m_pos % PER) >= BL) e_anode[e_idx] = m_mask[e_idx];
      check("model_anode_n",    anode_n,    e_anode);
      check("model_digit_nib",  digit_nib,  (m_disp >> (4 * e_idx)) & 16'hF);
      check("model_digit_idx",  digit_idx,  e_idx);
      check("model_frame_tick", frame_tick, m_tick);
      check("model_load_ready", load_ready, m_ready);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    check("frame_tick_seen", frame_tick, 1);
  endtask

  logic [3:0] t1_exp [8] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
  logic [3:0] t2_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    int n;
    reset_n = 1'b0; en = 1'b0; load_valid = 1'b0; load_data = '0; blank_mask = '0;
    step(3);
    check("rst_anode_n", anode_n, 4'hF);
    check("rst_load_ready", load_ready, 1);
    check("rst_digit_nib", digit_nib, 0);

    // 1: first lit pattern 2 cycles after release, lasting 4 cycles
    reset_n = 1'b1; en = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step(1);
      check("t1_anode_n", anode_n, t1_exp[j]);
    end

    // 2: load 4321, show 1,2,3,4 on successive anodes, tick every 24
    load_valid = 1'b1; load_data = 16'h4321;
    step(1);
    load_valid = 1'b0;
    check("t2_ready_low", load_ready, 0);
    wait_tick(n);
    for (int off = 1; off <= 24; off++) begin
      step(1);
      if (off % PER == BL) begin
        check("t2_nib", digit_nib, off / PER + 1);
        check("t2_anode", anode_n, t2_an[off / PER]);
      end
      if (off == 23) check("t2_no_tick", frame_tick, 0);
      if (off == 24) check("t2_tick24", frame_tick, 1);
    end

    // 3: load ABCD during digit 1 SHOW
    step(8);
    load_valid = 1'b1; load_data = 16'hABCD;
    step(1);
    load_valid = 1'b0;
    check("t3_ready_low", load_ready, 0);
    check("t3_old_nib", digit_nib, 2);
    wait_tick(n);
    check("t3_ready_back", load_ready, 1);
    check("t3_new_nib0", digit_nib, 4'hD);
    step(2);
    check("t3_lit_nib", digit_nib, 4'hD);
    check("t3_lit_anode", anode_n, 4'hE);

    // 4: back-to-back offers; second waits for ready
    load_valid = 1'b1; load_data = 16'h1111;
    step(1);
    load_data = 16'h2222;
    n = 0;
    do begin step(1); n++; end while (load_ready !== 1'b1 && n < 60);
    check("t4_ready_returns", load_ready, 1);
    check("t4_first_applied", digit_nib, 1);
    step(1);
    load_valid = 1'b0;
    wait_tick(n);
    check("t4_second_applied", digit_nib, 2);

    // 5: digit 2 masked
    blank_mask = 4'b0100;
    load_valid = 1'b1; load_data = 16'h5555;
    step(1);
    load_valid = 1'b0;
    wait_tick(n);
    step(8);
    check("t5_digit1_lit", anode_n, 4'hD);
    step(6);
    check("t5_digit2_dark", anode_n, 4'hF);
    check("t5_digit2_idx", digit_idx, 2);
    blank_mask = 4'b0000;
    wait_tick(n);
    check("t5_tick_timing", n, 10);

    // 6: drop en mid digit 2, then reset with a pending load
    step(14);
    en = 1'b0;
    step(1);
    check("t6_en_anode", anode_n, 4'hF);
    check("t6_en_idx", digit_idx, 0);
    load_valid = 1'b1; load_data = 16'h9999;
    step(1);
    load_valid = 1'b0;
    check("t6_pending", load_ready, 0);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1; en = 1'b1;
    check("t6_rst_ready", load_ready, 1);
    check("t6_rst_nib", digit_nib, 0);
    wait_tick(n);
    check("t6_discarded", digit_nib, 0);

    // Randomized traffic; the per-cycle model does the checking.
    for (int c = 0; c < 3000; c++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
      if ($urandom_range(0, 49) == 0) blank_mask = 4'($urandom);
      en      = ($urandom_range(0, 99) != 0);
      reset_n = ($urandom_range(0, 499) != 0);
      step(1);
    end
    reset_n = 1'b1; en = 1'b1; load_valid = 1'b0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
